branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the decode-stage branch comparator.
- Evaluates every MIPS conditional branch (BEQ/BNE/BLEZ/BGTZ and the REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL) over a configurable data width.
- Computes the branch target, link request and redirect PC, and flags mispredicts against the fetch prediction.
- Holds a DEPTH-entry 2-bit branch history table (BHT) that fetch reads and that resolution trains. Sits between decode and the hazard/fetch-redirect logic.

Parameters:
- DATA_W, 32, operand width for a/b comparisons
- PC_W, 32, program-counter width
- BHT_DEPTH, 64, BHT entries (power of two, ≥2)
- BHT_IDX_W, 6, log2(BHT_DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold the output register and freeze BHT update
- valid_i  in  1  decode slot holds a valid instruction
- opcode_i  in  6  instruction[31:26]
- rt_i  in  5  instruction[20:16]
- a_i  in  DATA_W  rs operand (forwarded)
- b_i  in  DATA_W  rt operand (forwarded)
- pc_i  in  PC_W  branch instruction PC
- imm_i  in  16  instruction[15:0]
- pred_taken_i  in  1  prediction fetch used for this instruction
- fetch_pc_i  in  PC_W  PC being fetched (BHT lookup)
- pred_taken_o  out  1  combinational BHT prediction for fetch_pc_i
- valid_o  out  1  registered result valid
- is_branch_o  out  1  instruction was a recognised conditional branch
- taken_o  out  1  resolved direction
- target_o  out  PC_W  pc_i + 4 + (sext(imm_i) << 2)
- redirect_pc_o  out  PC_W  taken ? target : pc_i + 8
- link_we_o  out  1  write $31 (BLTZAL/BGEZAL, regardless of direction)
- link_addr_o  out  PC_W  pc_i + 8
- mispredict_o  out  1  valid & is_branch & (taken != pred_taken_i)

Behaviour:
- Opcode encodings:
  - BEQ 000100: taken = a == b
  - BNE 000101: taken = a != b
  - BLEZ 000110: taken = a[DATA_W-1] | (a == 0)
  - BGTZ 000111: taken = ~a[DATA_W-1] & (a != 0)
- REGIMM 000001, selected by rt:
  - BLTZ 00000 / BLTZAL 10000: taken = a[DATA_W-1]
  - BGEZ 00001 / BGEZAL 10001: taken = ~a[DATA_W-1]
  - Any other rt: not a branch.
- Any other opcode: is_branch = 0, taken = 0, link_we = 0, mispredict = 0. valid_o still follows valid_i.
- Address arithmetic is modulo 2^PC_W, so wrap-around is silent. imm is sign-extended to PC_W before the shift.
- Latency is 1 cycle. On a clk edge with !rst & !stall_i, all outputs except pred_taken_o load the values computed from the current inputs.
- When valid_i = 0 the register loads valid_o = 0 and all flags 0. Address outputs are don't-care but must be driven.
- stall_i = 1: output register holds its value, and no BHT write occurs.
- Reset (any cycle, including mid-stall): valid_o, is_branch_o, taken_o, link_we_o, mispredict_o = 0; target_o, redirect_pc_o, link_addr_o = 0; every BHT counter = 2'b01 (weakly not-taken).
- BHT indexing: BHT index = pc[BHT_IDX_W+1:2]. pred_taken_o = counter[fetch_pc_i index][1], combinational.
- BHT update: on an edge with !rst & !stall_i & valid_i & is_branch, the counter at the pc_i index saturates +1 if taken, else −1 (3 stays 3, 0 stays 0).
- Same-cycle lookup and update of one index: pred_taken_o returns the pre-update value (no bypass).
- Non-branch or invalid instructions never touch the BHT.

Test Plan:
- Reset, then BEQ valid, a=b=32'h5, pred=0 → next cycle valid_o=1, taken_o=1, mispredict_o=1, target = pc+4+(imm<<2), redirect = target.
- BGTZ a=0 and BLEZ a=0: taken=0 and taken=1 respectively. BLTZ a=32'h8000_0000 gives taken=1; BGEZ on the same a gives taken=0.
- BLTZAL not taken, pc=32'h0040_0010 → link_we_o=1, link_addr_o=32'h0040_0018, redirect_pc_o=32'h0040_0018.
- imm=16'hFFFF, pc=32'h0000_0000 → target_o=32'h0000_0000; pc=32'hFFFF_FFF8, imm=0 → link_addr wraps to 32'h0000_0000.
- Train pc=32'h0040_0100 taken 3 times → counter reaches 3, pred_taken_o=1 for fetch_pc=32'h0040_0100. Then 2 not-taken → counter=1, pred_taken_o=0. A 4th taken while at 3 stays 3.
- stall_i=1 with a taken BNE on the inputs → outputs and BHT unchanged. rst asserted during the stall → all outputs 0 and all counters 01 next cycle. Non-branch opcode 100011 → is_branch_o=0, BHT unchanged.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves MIPS conditional branches (BEQ/BNE/BLEZ/BGTZ and the REGIMM
//   BLTZ/BGEZ/BLTZAL/BGEZAL) one cycle after decode. It computes the target,
//   redirect and link addresses and flags mispredicts against the fetch
//   prediction. It also owns a 2-bit-counter branch history table that fetch
//   reads combinationally and that resolution trains.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   stall_i                   hold the output register and freeze BHT training
//   valid_i, opcode_i, rt_i   decode slot contents
//   a_i, b_i                  forwarded rs / rt operands
//   pc_i, imm_i, pred_taken_i branch PC, offset, and direction fetch assumed
//   fetch_pc_i, pred_taken_o  BHT lookup for fetch (combinational)
//   valid_o .. mispredict_o   registered resolution results
module branch_resolve_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned BHT_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              valid_i,
    input  logic [5:0]        opcode_i,
    input  logic [4:0]        rt_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [15:0]       imm_i,
    input  logic              pred_taken_i,
    input  logic [PC_W-1:0]   fetch_pc_i,
    output logic              pred_taken_o,
    output logic              valid_o,
    output logic              is_branch_o,
    output logic              taken_o,
    output logic [PC_W-1:0]   target_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic              link_we_o,
    output logic [PC_W-1:0]   link_addr_o,
    output logic              mispredict_o
);

    logic                 is_branch, taken, link_we, a_zero, a_neg;
    logic [PC_W-1:0]      imm_sext, target, link_addr, redirect_pc;
    logic [BHT_IDX_W-1:0] upd_idx, fetch_idx;
    logic [1:0]           cnt_cur, cnt_next;
    logic [1:0]           bht_q [BHT_DEPTH];

    // Only the index bits of the fetch PC matter for the lookup.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc_i[PC_W-1:BHT_IDX_W+2], fetch_pc_i[1:0]};

    assign a_zero = (a_i == '0);
    assign a_neg  = a_i[DATA_W-1];

    // Direction decode
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        link_we   = 1'b0;
        case (opcode_i)
            6'b000100: begin is_branch = 1'b1; taken = (a_i == b_i);        end
            6'b000101: begin is_branch = 1'b1; taken = (a_i != b_i);        end
            6'b000110: begin is_branch = 1'b1; taken = a_neg | a_zero;      end
            6'b000111: begin is_branch = 1'b1; taken = ~a_neg & ~a_zero;    end
            6'b000001: begin
                case (rt_i)
                    5'b00000: begin is_branch = 1'b1; taken = a_neg;  end
                    5'b00001: begin is_branch = 1'b1; taken = ~a_neg; end
                    5'b10000: begin is_branch = 1'b1; taken = a_neg;  link_we = 1'b1; end
                    5'b10001: begin is_branch = 1'b1; taken = ~a_neg; link_we = 1'b1; end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

    // Address arithmetic wraps modulo 2^PC_W by construction.
    assign imm_sext    = {{(PC_W-16){imm_i[15]}}, imm_i};
    assign target      = pc_i + PC_W'(32'd4) + (imm_sext << 2);
    assign link_addr   = pc_i + PC_W'(32'd8);
    assign redirect_pc = taken ? target : link_addr;

    // BHT lookup and saturating update
    assign fetch_idx    = fetch_pc_i[BHT_IDX_W+1:2];
    assign upd_idx      = pc_i[BHT_IDX_W+1:2];
    assign pred_taken_o = bht_q[fetch_idx][1];
    assign cnt_cur      = bht_q[upd_idx];

    always_comb begin
        cnt_next = cnt_cur;
        if (taken) begin
            if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= 2'b01;
        end else if (!stall_i && valid_i && is_branch) begin
            bht_q[upd_idx] <= cnt_next;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o       <= 1'b0;
            is_branch_o   <= 1'b0;
            taken_o       <= 1'b0;
            link_we_o     <= 1'b0;
            mispredict_o  <= 1'b0;
            target_o      <= '0;
            redirect_pc_o <= '0;
            link_addr_o   <= '0;
        end else if (!stall_i) begin
            valid_o       <= valid_i;
            is_branch_o   <= valid_i & is_branch;
            taken_o       <= valid_i & taken;
            link_we_o     <= valid_i & link_we;
            mispredict_o  <= valid_i & is_branch & (taken != pred_taken_i);
            target_o      <= target;
            redirect_pc_o <= redirect_pc;
            link_addr_o   <= link_addr;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit: table of single-instruction
// vectors plus hand-written BHT training, stall and reset sequences.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, stall_i, valid_i, pred_taken_i;
    logic [5:0]  opcode_i;
    logic [4:0]  rt_i;
    logic [31:0] a_i, b_i, pc_i, fetch_pc_i;
    logic [15:0] imm_i;
    logic        pred_taken_o, valid_o, is_branch_o, taken_o, link_we_o, mispredict_o;
    logic [31:0] target_o, redirect_pc_o, link_addr_o;

    int n_cmp  = 0;
    int n_fail = 0;

    branch_resolve_unit #(
        .DATA_W(32), .PC_W(32), .BHT_DEPTH(64), .BHT_IDX_W(6)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid_i),
        .opcode_i(opcode_i), .rt_i(rt_i), .a_i(a_i), .b_i(b_i), .pc_i(pc_i),
        .imm_i(imm_i), .pred_taken_i(pred_taken_i), .fetch_pc_i(fetch_pc_i),
        .pred_taken_o(pred_taken_o), .valid_o(valid_o), .is_branch_o(is_branch_o),
        .taken_o(taken_o), .target_o(target_o), .redirect_pc_o(redirect_pc_o),
        .link_we_o(link_we_o), .link_addr_o(link_addr_o), .mispredict_o(mispredict_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        vld;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a, b, pc;
        logic [15:0] imm;
        logic        pred;
        logic        e_br, e_tk, e_lwe, e_mis;
        logic [31:0] e_tgt, e_rdr, e_lad;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111, OP_RI = 6'b000001, OP_LW = 6'b100011;

    task automatic add(input string name, input logic vld, input logic [5:0] op,
                       input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [15:0] imm, input logic pred,
                       input logic e_br, input logic e_tk, input logic e_lwe,
                       input logic e_mis, input logic [31:0] e_tgt,
                       input logic [31:0] e_rdr, input logic [31:0] e_lad);
        vec_t v;
        v.name = name; v.vld = vld; v.op = op; v.rt = rt; v.a = a; v.b = b;
        v.pc = pc; v.imm = imm; v.pred = pred; v.e_br = e_br; v.e_tk = e_tk;
        v.e_lwe = e_lwe; v.e_mis = e_mis; v.e_tgt = e_tgt; v.e_rdr = e_rdr;
        v.e_lad = e_lad;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [5:0] op, input logic [4:0] rt,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [15:0] imm, input logic pred);
        valid_i = vld; opcode_i = op; rt_i = rt; a_i = a; b_i = b; pc_i = pc;
        imm_i = imm; pred_taken_i = pred;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"},    valid_o, 0);
        chk({tag, " is_br"},    is_branch_o, 0);
        chk({tag, " taken"},    taken_o, 0);
        chk({tag, " link_we"},  link_we_o, 0);
        chk({tag, " mispred"},  mispredict_o, 0);
        chk({tag, " target"},   target_o, 0);
        chk({tag, " redirect"}, redirect_pc_o, 0);
        chk({tag, " link_adr"}, link_addr_o, 0);
    endtask

    // One training update at pc with the given direction, then check the prediction.
    task automatic train(input string tag, input logic [31:0] pc, input logic tk,
                         input logic exp_pred);
        // BEQ with a==b is taken, a!=b is not taken
        drive(1'b1, OP_BEQ, 5'd0, 32'd1, tk ? 32'd1 : 32'd2, pc, 16'd0, 1'b0);
        fetch_pc_i = pc;
        step();
        valid_i = 1'b0;
        chk(tag, pred_taken_o, exp_pred);
    endtask

    localparam logic [31:0] BP = 32'h0040_0100;

    initial begin
        rst = 1'b1; stall_i = 1'b0; fetch_pc_i = BP;
        drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0);

        //   name         vld op       rt         a             b      pc            imm       pred br tk lwe mis target        redirect      link_addr
        add("beq_eq",     1, OP_BEQ,  5'd0,  32'h5,        32'h5, 32'h0000_1000, 16'h0010, 0, 1, 1, 0, 1, 32'h0000_1044, 32'h0000_1044, 32'h0000_1008);
        add("bgtz_zero",  1, OP_BGTZ, 5'd0,  32'h0,        32'h0, 32'h0000_2000, 16'h0004, 0, 1, 0, 0, 0, 32'h0000_2014, 32'h0000_2008, 32'h0000_2008);
        add("blez_zero",  1, OP_BLEZ, 5'd0,  32'h0,        32'h0, 32'h0000_2000, 16'h0004, 1, 1, 1, 0, 0, 32'h0000_2014, 32'h0000_2014, 32'h0000_2008);
        add("bltz_neg",   1, OP_RI,   5'd0,  32'h8000_0000,32'h0, 32'h0000_3000, 16'hFFFF, 0, 1, 1, 0, 1, 32'h0000_3000, 32'h0000_3000, 32'h0000_3008);
        add("bgez_neg",   1, OP_RI,   5'd1,  32'h8000_0000,32'h0, 32'h0000_3000, 16'hFFFF, 0, 1, 0, 0, 0, 32'h0000_3000, 32'h0000_3008, 32'h0000_3008);
        add("bltzal_nt",  1, OP_RI,   5'd16, 32'h5,        32'h0, 32'h0040_0010, 16'h0008, 1, 1, 0, 1, 1, 32'h0040_0034, 32'h0040_0018, 32'h0040_0018);
        add("bgezal_tk",  1, OP_RI,   5'd17, 32'h5,        32'h0, 32'h0000_5000, 16'h0001, 1, 1, 1, 1, 0, 32'h0000_5008, 32'h0000_5008, 32'h0000_5008);
        add("imm_wrap",   1, OP_BEQ,  5'd0,  32'h1,        32'h2, 32'h0000_0000, 16'hFFFF, 0, 1, 0, 0, 0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0008);
        add("link_wrap",  1, OP_BNE,  5'd0,  32'h1,        32'h2, 32'hFFFF_FFF8, 16'h0000, 1, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
        add("bne_eq",     1, OP_BNE,  5'd0,  32'h7,        32'h7, 32'h0000_7000, 16'h0002, 1, 1, 0, 0, 1, 32'h0000_700C, 32'h0000_7008, 32'h0000_7008);
        add("bgtz_pos",   1, OP_BGTZ, 5'd0,  32'h1,        32'h0, 32'h0000_8000, 16'h0003, 0, 1, 1, 0, 1, 32'h0000_8010, 32'h0000_8010, 32'h0000_8008);
        add("lw_nonbr",   1, OP_LW,   5'd0,  32'h0,        32'h0, 32'h0000_6000, 16'h0000, 1, 0, 0, 0, 0, 32'h0000_6004, 32'h0000_6008, 32'h0000_6008);
        add("ri_bad_rt",  1, OP_RI,   5'd2,  32'h8000_0000,32'h0, 32'h0000_6000, 16'h0000, 1, 0, 0, 0, 0, 32'h0000_6004, 32'h0000_6008, 32'h0000_6008);
        add("invalid",    0, OP_BEQ,  5'd0,  32'h5,        32'h5, 32'h0000_1000, 16'h0010, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0);

        do_reset();
        chk_zero("reset");
        chk("reset pred", pred_taken_o, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].rt, vecs[i].a, vecs[i].b, vecs[i].pc,
                  vecs[i].imm, vecs[i].pred);
            step();
            chk({vecs[i].name, " valid"},   valid_o,      vecs[i].vld);
            chk({vecs[i].name, " is_br"},   is_branch_o,  vecs[i].e_br);
            chk({vecs[i].name, " taken"},   taken_o,      vecs[i].e_tk);
            chk({vecs[i].name, " link_we"}, link_we_o,    vecs[i].e_lwe);
            chk({vecs[i].name, " mispred"}, mispredict_o, vecs[i].e_mis);
            if (vecs[i].vld) begin
                chk({vecs[i].name, " target"},   target_o,      vecs[i].e_tgt);
                chk({vecs[i].name, " redirect"}, redirect_pc_o, vecs[i].e_rdr);
                chk({vecs[i].name, " link_adr"}, link_addr_o,   vecs[i].e_lad);
            end
        end

        // BHT training with saturation at both ends
        do_reset();
        train("bht t1", BP, 1, 1);   // 01 -> 10
        train("bht t2", BP, 1, 1);   // 11
        train("bht t3", BP, 1, 1);   // 11
        train("bht t4", BP, 1, 1);   // stays 11
        train("bht n1", BP, 0, 1);   // 10 (would be 0 if 11 had wrapped)
        train("bht n2", BP, 0, 0);   // 01
        train("bht n3", BP, 0, 0);   // 00
        train("bht n4", BP, 0, 0);   // stays 00
        train("bht t5", BP, 1, 0);   // 01
        train("bht t6", BP, 1, 1);   // 10
        fetch_pc_i = BP + 32'd4;
        #1 chk("bht other idx", pred_taken_o, 0);

        // Same-cycle lookup of the index being updated sees the old counter
        do_reset();
        drive(1'b1, OP_BEQ, 5'd0, 32'd3, 32'd3, BP, 16'd0, 1'b0);
        fetch_pc_i = BP;
        #1 chk("no bypass", pred_taken_o, 0);
        step();
        valid_i = 1'b0;
        chk("after update", pred_taken_o, 1);

        // Invalid and non-branch instructions never train
        do_reset();
        drive(1'b0, OP_BEQ, 5'd0, 32'd3, 32'd3, BP, 16'd0, 1'b0);
        step();
        chk("invalid no train", pred_taken_o, 0);
        drive(1'b1, OP_LW, 5'd0, 32'd3, 32'd3, BP, 16'd0, 1'b0);
        step();
        step();
        chk("lw is_br", is_branch_o, 0);
        train("lw no train", BP, 1, 1);  // still 01 -> 10

        // Stall holds outputs and freezes the BHT
        do_reset();
        drive(1'b1, OP_BEQ, 5'd0, 32'd5, 32'd5, BP, 16'h0010, 1'b0);
        fetch_pc_i = BP + 32'd4;
        step();
        drive(1'b1, OP_BNE, 5'd0, 32'd1, 32'd2, BP + 32'd4, 16'h0000, 1'b1);
        stall_i = 1'b1;
        step();
        step();
        chk("stall valid",    valid_o, 1);
        chk("stall taken",    taken_o, 1);
        chk("stall mispred",  mispredict_o, 1);
        chk("stall target",   target_o, 32'h0040_0144);
        chk("stall redirect", redirect_pc_o, 32'h0040_0144);
        chk("stall link_adr", link_addr_o, 32'h0040_0108);
        chk("stall bht", pred_taken_o, 0);
        fetch_pc_i = BP;
        #1 chk("stall bht prev", pred_taken_o, 1);

        // Reset while stalled clears everything
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall_i = 1'b0;
        valid_i = 1'b0;
        chk_zero("rst in stall");
        chk("rst in stall bht", pred_taken_o, 0);
        train("rst cnt 01", BP, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
